// File: rtl/cdc_pkg.sv
// Shared types and helpers for the CDC handshake sender.
// Holds the FSM state encoding and the timeout counter width.
package cdc_pkg;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_REQ,
        HS_DROP,
        HS_ERR
    } cdc_hs_state_e;

    // Counter must reach n-1 without wrapping; never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        int w;
        w = $clog2(n + 1);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/cdc_hs_sender.sv
// Source-domain 4-phase req/ack sender with optional ack timeout.
// ack_i arrives already synchronized; this block is single-clock.
module cdc_hs_sender
    import cdc_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             req_o,
    input  logic             ack_i,
    output logic             done_o,
    output logic             timeout_o,
    input  logic             clear_timeout_i
);

    localparam int CW = cnt_w(TIMEOUT_CYCLES);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] TO_LAST =
        TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

    cdc_hs_state_e    r_state;
    cdc_hs_state_e    w_state_nxt;
    logic             r_req;
    logic             w_req_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_to;
    logic             w_to_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [CW-1:0]    w_cnt_inc;
    logic             w_expire;
    logic             w_ready;

    // A stale-high ack from the previous cycle blocks a new accept.
    assign w_ready   = (r_state == HS_IDLE) && !ack_i && !rst_i;
    assign w_expire  = TO_EN && (r_cnt == TO_LAST);
    assign w_cnt_inc = TO_EN ? (r_cnt + CW'(1)) : '0;

    assign ready_o   = w_ready;
    assign data_o    = r_data;
    assign req_o     = r_req;
    assign done_o    = r_done;
    assign timeout_o = r_to;

    // Next-state and next-output logic for the 4-phase handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        w_to_nxt    = r_to;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            HS_IDLE: begin
                if (valid_i && w_ready) begin
                    w_data_nxt  = data_i;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = HS_REQ;
                end
            end
            HS_REQ: begin
                if (ack_i) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = HS_DROP;
                end else if (w_expire) begin
                    w_req_nxt   = 1'b0;
                    w_to_nxt    = 1'b1;
                    w_state_nxt = HS_ERR;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            HS_DROP: begin
                if (!ack_i) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = HS_IDLE;
                end else if (w_expire) begin
                    w_req_nxt   = 1'b0;
                    w_to_nxt    = 1'b1;
                    w_state_nxt = HS_ERR;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            HS_ERR: begin
                if (clear_timeout_i && !ack_i) begin
                    w_to_nxt    = 1'b0;
                    w_state_nxt = HS_IDLE;
                end
            end
        endcase
        if (w_state_nxt != r_state) w_cnt_nxt = '0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= HS_IDLE;
            r_req   <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_to    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
            r_to    <= w_to_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_cdc_hs_sender.sv
// Randomized bench for cdc_hs_sender with a transaction-level model.
// Accepted words are queued and checked when done_o reports them.
module tb_cdc_hs_sender;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        ack;
    logic        clr;
    logic [31:0] din;
    logic        ready_o;
    logic [31:0] data_o;
    logic        req_o;
    logic        done_o;
    logic        timeout_o;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int rx_w = 0;

    // Reference model: phase 0 idle, 1 waiting ack rise,
    // 2 waiting ack fall, 3 dead receiver.
    int          m_phase = 0;
    int          m_age = 0;
    logic        m_req = 1'b0;
    logic        m_done = 1'b0;
    logic        m_to = 1'b0;
    logic [31:0] m_data = '0;
    logic [31:0] exp_q[$];

    cdc_hs_sender #(
        .WIDTH(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .valid_i(valid),
        .ready_o(ready_o),
        .data_i(din),
        .data_o(data_o),
        .req_o(req_o),
        .ack_i(ack),
        .done_o(done_o),
        .timeout_o(timeout_o),
        .clear_timeout_i(clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // A waiting phase gives up once it has lasted TO cycles.
    function automatic bit expired(input int age);
        return (TO > 0) && (age + 1 >= TO);
    endfunction

    // Model update at each active edge.
    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_phase = 0;
            m_age   = 0;
            m_req   = 1'b0;
            m_to    = 1'b0;
            m_data  = '0;
            exp_q.delete();
        end else if (m_phase == 0) begin
            if (valid && !ack) begin
                m_data  = din;
                m_req   = 1'b1;
                m_phase = 1;
                m_age   = 0;
                exp_q.push_back(din);
            end
        end else if (m_phase == 1 || m_phase == 2) begin
            if ((m_phase == 1) == ack) begin
                if (m_phase == 2) m_done = 1'b1;
                m_req   = 1'b0;
                m_phase = (m_phase == 1) ? 2 : 0;
                m_age   = 0;
            end else if (expired(m_age)) begin
                m_req   = 1'b0;
                m_to    = 1'b1;
                m_phase = 3;
                m_age   = 0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else begin
                m_age++;
            end
        end else begin
            if (clr && !ack) begin
                m_to    = 1'b0;
                m_phase = 0;
            end
        end
        chk_en = 1'b1;
    end

    // Monitor: per-cycle output checks and done_o scoreboard pops.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready_o", 32'(ready_o),
                  32'((m_phase == 0) && !ack && !rst));
            check("req_o", 32'(req_o), 32'(m_req));
            check("timeout_o", 32'(timeout_o), 32'(m_to));
            check("done_o", 32'(done_o), 32'(m_done));
            check("data_o", data_o, m_data);
            if (done_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("done_without_word", 32'(done_o), 32'(0));
                end else begin
                    check("done_word", data_o, exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Receiver: follow req_o with a random delay on each edge of ack.
    task automatic rx_drive(input int maxd);
        if (ack != req_o) begin
            if (rx_w <= 0) begin
                ack  = req_o;
                rx_w = $urandom_range(0, maxd);
            end else begin
                rx_w--;
            end
        end
    endtask

    task automatic rand_phase(input int cycles, input int maxd);
        for (int i = 0; i < cycles; i++) begin
            valid = ($urandom_range(0, 9) < 7);
            din   = $urandom;
            rst   = ($urandom_range(0, 299) == 0);
            clr   = timeout_o ? ($urandom_range(0, 2) == 0)
                              : ($urandom_range(0, 15) == 0);
            rx_drive(maxd);
            step();
        end
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b1;
        din   = 32'hA5A5A5A5;
        ack   = 1'b0;
        clr   = 1'b0;
        repeat (3) step();
        rst   = 1'b0;
        valid = 1'b0;
        repeat (2) step();

        // Basic transfer with data_i changing under back-pressure.
        valid = 1'b1;
        din   = 32'hDEADBEEF;
        step();
        din = $urandom;
        step();
        din = $urandom;
        step();
        ack = 1'b1;
        din = $urandom;
        step();
        din = $urandom;
        step();
        din = $urandom;
        step();
        ack = 1'b0;
        din = $urandom;
        step();
        din = 32'h12345678;
        step();
        valid = 1'b0;
        step();
        ack = 1'b1;
        repeat (2) step();
        ack = 1'b0;
        repeat (3) step();

        // Stale ack blocks acceptance.
        ack   = 1'b1;
        valid = 1'b1;
        din   = 32'hCAFEF00D;
        repeat (3) step();
        ack = 1'b0;
        step();
        valid = 1'b0;
        step();
        ack = 1'b1;
        repeat (2) step();
        ack = 1'b0;
        repeat (3) step();

        // Timeout waiting for ack rise, then clear.
        valid = 1'b1;
        din   = 32'h0BADF00D;
        step();
        valid = 1'b0;
        repeat (12) step();
        ack = 1'b1;
        clr = 1'b1;
        step();
        ack = 1'b0;
        clr = 1'b0;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (2) step();

        // Ack arrives in the last allowed cycle: exit wins.
        valid = 1'b1;
        din   = 32'h55AA55AA;
        step();
        valid = 1'b0;
        repeat (7) step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        repeat (3) step();

        // Timeout waiting for ack fall.
        valid = 1'b1;
        din   = 32'h11223344;
        step();
        valid = 1'b0;
        step();
        ack = 1'b1;
        repeat (12) step();
        ack = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (2) step();

        // Reset while waiting for ack fall.
        valid = 1'b1;
        din   = 32'h99887766;
        step();
        valid = 1'b0;
        step();
        ack = 1'b1;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        ack = 1'b0;
        repeat (3) step();

        rand_phase(2000, 4);
        rand_phase(1500, 12);
        valid = 1'b0;
        rst   = 1'b0;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
